seg_scan_display: RTL and testbench

Parametrised multiplexed seven-segment driver for the game's score and level readouts. It accepts a binary value on a load strobe and converts it to BCD sequentially, one shift-add step per cycle. It then scans DIGITS common-anode digits at a programmable refresh rate. The scan supports per-digit enable, leading-zero blanking, per-digit blinking and an overflow indication. It replaces the fixed two-digit score scanner and sits between the game FSM and the board pins.

---
 rtl/seg_scan_display.sv | 183 ++++++++++++++++++
 tb/tb_seg_scan_display.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver: sequential double-dabble binary-to-BCD
// conversion feeding a prescaled digit scanner with enable, blanking, blink and overflow.
module seg_scan_display #(
    parameter int DIGITS       = 4,
    parameter int VAL_W        = 10,
    parameter int REFRESH_DIV  = 131072,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [VAL_W-1:0]  val,
    input  logic [DIGITS-1:0] dig_en,
    input  logic [DIGITS-1:0] blink_en,
    input  logic              lz_blank,
    output logic              busy,
    output logic              ovf,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg
);

    localparam int NIB = DIGITS + 1;
    localparam int TW  = 4 * NIB + VAL_W;
    localparam int CW  = $clog2(VAL_W + 1);
    localparam int PW  = $clog2(REFRESH_DIV);
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [4*NIB-1:0] dabble_adj(input logic [4*NIB-1:0] b);
        logic [4*NIB-1:0] r;
        r = b;
        for (int i = 0; i < NIB; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Conversion stage: working BCD nibbles + binary shift register
    logic [4*NIB-1:0]       bcd_q;
    logic [VAL_W-1:0]       sh_q;
    logic [CW-1:0]          step_q;
    logic                   busy_q;
    logic [TW-1:0]          cat;
    logic [TW-1:0]          cat_sh;
    logic                   last_step;
    logic [DIGITS-1:0][3:0] dig_q;
    logic                   ovf_q;

    assign cat       = {dabble_adj(bcd_q), sh_q};
    assign cat_sh    = {cat[TW-2:0], 1'b0};
    assign last_step = busy_q && (step_q == CW'(VAL_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            step_q <= '0;
        end else if (load) begin
            busy_q <= 1'b1;
            step_q <= '0;
        end else if (busy_q) begin
            step_q <= step_q + CW'(1);
            if (last_step)
                busy_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            bcd_q <= '0;
            sh_q  <= val;
        end else if (busy_q) begin
            bcd_q <= cat_sh[TW-1:VAL_W];
            sh_q  <= cat_sh[VAL_W-1:0];
        end
    end

    // Commit stage: the final step lands all digits at once, so the scanner never sees partial BCD
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q <= '0;
            ovf_q <= 1'b0;
        end else if (last_step) begin
            dig_q <= cat_sh[VAL_W +: 4*DIGITS];
            ovf_q <= (cat_sh[VAL_W + 4*DIGITS +: 4] != 4'd0);
        end
    end

    // Scan stage: prescaler, digit index, frame counter and blink phase
    logic [PW-1:0]     presc_q;
    logic [IW-1:0]     idx_q;
    logic [FW-1:0]     frame_q;
    logic              phase_q;
    logic              tick;
    logic              idx_last;
    logic              hi_zero;
    logic [DIGITS-1:0] an_nxt;
    logic [6:0]        seg_nxt;
    logic [DIGITS-1:0] an_q;
    logic [6:0]        seg_q;

    assign tick     = (presc_q == PW'(REFRESH_DIV - 1));
    assign idx_last = (idx_q == IW'(DIGITS - 1));

    always_comb begin
        hi_zero = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (IW'(j) >= idx_q && dig_q[j] != 4'd0)
                hi_zero = 1'b0;
        end
    end

    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_BLANK;
        if (!dig_en[idx_q]) begin
            an_nxt = '1;
        end else if (phase_q && blink_en[idx_q]) begin
            an_nxt = '1;
        end else if (ovf_q) begin
            an_nxt[idx_q] = 1'b0;
            seg_nxt       = SEG_DASH;
        end else if (lz_blank && idx_q != '0 && hi_zero) begin
            an_nxt = '1;
        end else begin
            an_nxt[idx_q] = 1'b0;
            seg_nxt       = seg_code(dig_q[idx_q]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                an_q  <= an_nxt;
                seg_q <= seg_nxt;
                idx_q <= idx_last ? '0 : idx_q + IW'(1);
                if (idx_last) begin
                    if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                        frame_q <= '0;
                        phase_q <= ~phase_q;
                    end else begin
                        frame_q <= frame_q + FW'(1);
                    end
                end
            end
        end
    end

    assign busy = busy_q;
    assign ovf  = ovf_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: a cycle-level decimal reference model
// queues expected outputs each clock; a negedge monitor pops and compares.
module tb_seg_scan_display;

  localparam int DIGITS       = 4;
  localparam int VAL_W        = 14;
  localparam int REFRESH_DIV  = 4;
  localparam int BLINK_FRAMES = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load = 1'b0;
  logic [VAL_W-1:0]  val = '0;
  logic [DIGITS-1:0] dig_en = '1;
  logic [DIGITS-1:0] blink_en = '0;
  logic              lz_blank = 1'b0;
  logic              busy;
  logic              ovf;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;

  seg_scan_display #(
    .DIGITS(DIGITS), .VAL_W(VAL_W), .REFRESH_DIV(REFRESH_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .val(val), .dig_en(dig_en),
    .blink_en(blink_en), .lz_blank(lz_blank), .busy(busy), .ovf(ovf),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              busy;
    logic              ovf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Reference model: decimal arithmetic on the committed value, timing from an edge count
  int                k = 0;
  int                committed = 0;
  int                pend_val = 0;
  int                due = 0;
  bit                pending = 0;
  logic [DIGITS-1:0] m_an = '1;
  logic [6:0]        m_seg = 7'b1111111;

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      k = 0; committed = 0; pending = 0;
      m_an = '1; m_seg = 7'b1111111;
      e = '{an: '1, seg: 7'b1111111, busy: 1'b0, ovf: 1'b0};
    end else begin
      if (k % REFRESH_DIV == REFRESH_DIV - 1) begin
        int n, i, ph;
        bit o;
        n  = k / REFRESH_DIV;
        i  = n % DIGITS;
        ph = (n / DIGITS / BLINK_FRAMES) % 2;
        o  = committed > pow10(DIGITS) - 1;
        m_an = '1; m_seg = 7'b1111111;
        if (!dig_en[i] || (ph == 1 && blink_en[i])) begin
          m_an = '1;
        end else if (o) begin
          m_an[i] = 1'b0; m_seg = 7'b0111111;
        end else if (lz_blank && i != 0 && committed < pow10(i)) begin
          m_an = '1;
        end else begin
          m_an[i] = 1'b0;
          m_seg = digit_seg((committed / pow10(i)) % 10);
        end
      end
      if (pending && k == due) begin
        committed = pend_val;
        pending = 0;
      end
      if (load) begin
        pending = 1; pend_val = int'(val); due = k + VAL_W;
      end
      e.an = m_an; e.seg = m_seg; e.busy = pending;
      e.ovf = committed > pow10(DIGITS) - 1;
      k++;
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (an !== e.an || seg !== e.seg || busy !== e.busy || ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got an=%b seg=%b busy=%b ovf=%b, want an=%b seg=%b busy=%b ovf=%b",
                 $time, an, seg, busy, ovf, e.an, e.seg, e.busy, e.ovf);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    val  = VAL_W'(v);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic expect_reset_outputs();
    n_checks++;
    if (an !== '1 || seg !== 7'b1111111 || busy !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset state t=%0t: an=%b seg=%b busy=%b ovf=%b", $time, an, seg, busy, ovf);
    end
  endtask

  task automatic wait_busy_low(input int limit);
    int w;
    w = 0;
    while (busy === 1'b1 && w < limit) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait expired t=%0t: busy still high after %0d cycles", $time, limit);
    end
  endtask

  initial begin
    @(negedge clk);
    cyc(3);
    expect_reset_outputs();
    rst = 1'b0;
    cyc(20);
    do_load(937);
    wait_busy_low(VAL_W + 2);
    cyc(30);
    lz_blank = 1'b1;
    cyc(20);
    do_load(0);
    cyc(40);
    lz_blank = 1'b0;
    do_load(12345);
    wait_busy_low(VAL_W + 2);
    cyc(30);
    do_load(42);
    cyc(40);
    do_load(500);
    cyc(2);
    do_load(21);
    wait_busy_low(VAL_W + 2);
    cyc(30);
    blink_en = 4'b0001;
    cyc(150);
    blink_en = 4'b0000;

    for (int it = 0; it < 300; it++) begin
      int g, v, sel;
      if ($urandom_range(0, 3) == 0) dig_en   = DIGITS'($urandom);
      if ($urandom_range(0, 3) == 0) blink_en = DIGITS'($urandom);
      if ($urandom_range(0, 3) == 0) lz_blank = 1'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0)      v = $urandom_range(0, 99);
      else if (sel == 1) v = $urandom_range(10000, (1 << VAL_W) - 1);
      else               v = $urandom_range(0, (1 << VAL_W) - 1);
      do_load(v);
      g = $urandom_range(0, 30);
      if (g + 1 == VAL_W) g++;
      cyc(g);
      if (it == 150) begin
        rst = 1'b1; load = 1'b1; val = VAL_W'(777);
        @(negedge clk);
        expect_reset_outputs();
        rst = 1'b0; load = 1'b0;
      end
    end

    cyc(40);
    do_load(0);
    cyc(5);
    rst = 1'b1; load = 1'b1; val = VAL_W'(1234);
    @(negedge clk);
    expect_reset_outputs();
    rst = 1'b0; load = 1'b0;
    cyc(40);
    @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
